// File: rtl/lpf_line_feeder.sv
// lpf_line_feeder: line-oriented front end for the luma LPF/FIR.
// Accepts one line at a time over valid/ready and pushes it to the FIR.
// Each line is edge-padded with P=(FW-1)/2 copies of the first and last pixel.
module lpf_line_feeder #(
  parameter int DW = 10,
  parameter int FW = 7,
  parameter int LW = 12
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clear,
  input  logic [LW-1:0] LineLen,
  input  logic [DW-1:0] PixIn,
  input  logic          PixInVld,
  input  logic          PixInSol,
  output logic          PixInRdy,
  output logic [DW-1:0] DataIn,
  output logic          DataInVld,
  output logic          LineDone,
  output logic          Busy,
  output logic          Err
);

  localparam int P  = (FW - 1) / 2;
  // The pad counter only needs to reach P-1.
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] PAD_LAST = PW'(P - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_POST = 2'd3;

  logic [1:0]    state_r,    state_nxt_s;
  logic [PW-1:0] pad_cnt_r,  pad_nxt_s;
  logic [LW-1:0] pix_cnt_r,  pix_nxt_s;
  logic [LW-1:0] len_r,      len_nxt_s;
  logic [DW-1:0] last_r,     last_nxt_s;
  logic [DW-1:0] data_in_r;
  logic          data_vld_r;
  logic          line_done_r, done_nxt_s;
  logic          busy_r;
  logic          err_r,      err_nxt_s;
  logic          launch_s;
  logic [DW-1:0] launch_data_s;
  logic          accept_s;
  logic [LW-1:0] pix_inc_s;

  // Ready follows the state only; a pending reset/clear blocks any accept.
  assign PixInRdy  = ~Rst & ~Clear & ((state_r == ST_IDLE) | (state_r == ST_BODY));
  assign accept_s  = PixInVld & PixInRdy;
  assign pix_inc_s = pix_cnt_r + LW'(1);

  // Next-state, counter updates and sample launch selection.
  always_comb begin
    state_nxt_s   = state_r;
    pad_nxt_s     = pad_cnt_r;
    pix_nxt_s     = pix_cnt_r;
    len_nxt_s     = len_r;
    last_nxt_s    = last_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = err_r;
    launch_s      = 1'b0;
    launch_data_s = last_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (PixInSol) begin
            if (LineLen != LW'(0)) begin
              len_nxt_s     = LineLen;
              last_nxt_s    = PixIn;
              launch_s      = 1'b1;
              launch_data_s = PixIn;
              pix_nxt_s     = LW'(1);
              pad_nxt_s     = PW'(0);
              state_nxt_s   = ST_PRE;
            end else begin
              // Empty line: nothing to filter, just report completion.
              done_nxt_s = 1'b1;
            end
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        launch_s = 1'b1;
        if (pad_cnt_r == PAD_LAST) begin
          pad_nxt_s   = PW'(0);
          state_nxt_s = (len_r > LW'(1)) ? ST_BODY : ST_POST;
        end else begin
          pad_nxt_s = pad_cnt_r + PW'(1);
        end
      end
      ST_BODY: begin
        if (accept_s) begin
          launch_s      = 1'b1;
          launch_data_s = PixIn;
          last_nxt_s    = PixIn;
          pix_nxt_s     = pix_inc_s;
          if (PixInSol) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
          if (pix_inc_s == len_r) begin
            pad_nxt_s   = PW'(0);
            state_nxt_s = ST_POST;
          end else begin
            state_nxt_s = ST_BODY;
          end
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      ST_POST: begin
        launch_s = 1'b1;
        if (pad_cnt_r == PAD_LAST) begin
          pad_nxt_s   = PW'(0);
          pix_nxt_s   = LW'(0);
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          pad_nxt_s = pad_cnt_r + PW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pad_nxt_s   = PW'(0);
        pix_nxt_s   = LW'(0);
      end
    endcase
  end

  // State, counters and registered outputs; Rst and Clear abandon any line.
  always_ff @(posedge Clk) begin
    if (Rst || Clear) begin
      state_r     <= ST_IDLE;
      pad_cnt_r   <= PW'(0);
      pix_cnt_r   <= LW'(0);
      len_r       <= LW'(0);
      last_r      <= DW'(0);
      data_in_r   <= DW'(0);
      data_vld_r  <= 1'b0;
      line_done_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pad_cnt_r   <= pad_nxt_s;
      pix_cnt_r   <= pix_nxt_s;
      len_r       <= len_nxt_s;
      last_r      <= last_nxt_s;
      data_in_r   <= launch_s ? launch_data_s : data_in_r;
      data_vld_r  <= launch_s;
      line_done_r <= done_nxt_s;
      // Busy spans the whole output window, including the final strobe.
      busy_r      <= launch_s | (state_nxt_s != ST_IDLE);
      err_r       <= err_nxt_s;
    end
  end

  assign DataIn    = data_in_r;
  assign DataInVld = data_vld_r;
  assign LineDone  = line_done_r;
  assign Busy      = busy_r;
  assign Err       = err_r;

endmodule

// File: doc/lpf_line_feeder.md
Name: lpf_line_feeder

Overview:
- Transmit-side front end for the luma LPF/FIR sample interface. It drives the `DataIn`/`DataInVld` stream that the FIR consumes.
- Accepts one line of pixels at a time over a valid/ready handshake.
- Edge-pads each line for the symmetric filter window: replicates the first pixel (FW-1)/2 times before the line and the last pixel (FW-1)/2 times after it.
- Sits between the line source and the FIR. The FIR has no backpressure, so output is push-only.

Parameters:
- DW, 10, pixel/sample width.
- FW, 7, filter tap count; must be odd and ≥3. P = (FW-1)/2 is the pad count per edge.
- LW, 12, width of the line-length field; max line is 2^LW-1 pixels.

Ports:
- Clk  input  1  single clock, all logic rising-edge.
- Rst  input  1  synchronous active-high reset.
- Clear  input  1  synchronous active-high soft clear. Same effect as Rst.
- LineLen  input  LW  pixels in the line; latched when the start-of-line pixel is accepted.
- PixIn  input  DW  input pixel.
- PixInVld  input  1  PixIn valid.
- PixInSol  input  1  marks the first pixel of a line; qualified by PixInVld.
- PixInRdy  output  1  feeder can accept PixIn this cycle.
- DataIn  output  DW  sample to the FIR; registered.
- DataInVld  output  1  DataIn valid strobe; registered.
- LineDone  output  1  one-cycle pulse at line completion.
- Busy  output  1  high in any state other than IDLE.
- Err  output  1  sticky protocol-error flag.

Behaviour:
- Reset/Clear values (next edge): DataIn=0, DataInVld=0, LineDone=0, Err=0, state=IDLE, all counters=0. PixInRdy is 0 while Rst or Clear is high.
- Rst or Clear mid-line abandons the line: no further DataInVld, no LineDone.
- Accept happens when PixInVld && PixInRdy.
- PixInRdy is combinational from state: 1 in IDLE and BODY, 0 in PRE and POST.
- Launch timing: a sample launched in cycle c appears on DataIn with DataInVld=1 in cycle c+1. DataInVld=0 in any cycle with no launch. DataIn holds its last value when not valid.
- FSM states: IDLE, PRE, BODY, POST. Counters: pad_cnt (P), pix_cnt (LW bits).
- IDLE:
  - Accept with Sol=1 and LineLen≥1: latch LineLen and p0, launch p0, pix_cnt=1, go to PRE.
  - Accept with Sol=1 and LineLen=0: pixel dropped, no launch, LineDone=1 next cycle, stay in IDLE.
  - Accept with Sol=0: pixel dropped, Err←1, stay in IDLE.
- PRE: launch the latched p0 every cycle for exactly P cycles. On the last cycle go to BODY if LineLen>1, else go to POST.
- BODY:
  - Each accept launches PixIn, updates the last-pixel register and increments pix_cnt.
  - Gaps in PixInVld produce gaps in DataInVld. Content is unchanged.
  - Accept with Sol=1 sets Err←1; the pixel is still treated as a body pixel.
  - The accept that brings pix_cnt to LineLen moves the FSM to POST.
- POST: launch the last pixel every cycle for exactly P cycles. LineDone coincides with the final DataInVld of the line. Then go to IDLE; the next SOL can be accepted in the cycle after LineDone.
- Per line with N≥1: exactly N+2P DataInVld strobes, in the order p0×(P+1), p1..p(N-2), p(N-1)×(P+1).
- With a contiguous supply, output is gap-free from the first to the last sample.
- Err clears only on Rst or Clear.
- Width rules: pix_cnt compare is unsigned LW bits, with no wrap within a line. Pixel data passes through unmodified.

Test Plan (FW=7, P=3):
- LineLen=4, pixels 10,20,30,40 presented continuously: DataIn = 10,10,10,10,20,30,40,40,40,40 on 10 consecutive DataInVld cycles. PixInRdy is low for 3 cycles after p0 and for 3 cycles after 40. LineDone is high with the final 40.
- LineLen=1, pixel 5: exactly 7 consecutive strobes of 5. BODY is skipped. LineDone is high on the 7th strobe. Busy=1 for 7 cycles.
- LineLen=4, PixInVld toggling 1/0 in BODY: same 10-value sequence, with DataInVld holes matching the input holes.
- Pixel with PixInVld=1, PixInSol=0 in IDLE: no DataInVld, Err=1 and sticky. Pulse Clear: Err=0 and the next line works normally.
- Rst asserted in the 2nd BODY cycle: DataInVld=0 from the next cycle, no LineDone. A fresh LineLen=2 line afterwards gives a,a,a,a,b,b,b,b.
- LineLen=0 SOL pixel accepted: no DataInVld, LineDone pulse in the following cycle, FSM stays in IDLE.
